// File: rtl/somador_pkg.sv
// Shared widths and operand/result types for the somador_8bits adder.
package somador_pkg;

  localparam int unsigned SOMA_WIDTH     = 7;
  localparam int unsigned SOMA_RES_WIDTH = SOMA_WIDTH + 1;

  typedef logic [SOMA_WIDTH-1:0]     operand_t;
  typedef logic [SOMA_RES_WIDTH-1:0] result_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/somador_8bits.sv
// Registered ripple-carry adder with carry-in and one cycle of latency.
// Define SOMADOR_OVF_EN to add the registered signed-overflow output ovf.
module somador_8bits
  import somador_pkg::*;
#(
  parameter int unsigned WIDTH = SOMA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] S1,
  input  logic [WIDTH-1:0] S2,
  input  logic             C_in,
  input  logic             in_valid,
  output logic [WIDTH:0]   resultado,
  output logic             C_out,
  output logic             out_valid
`ifdef SOMADOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = C_in;

  // Ripple chain: carry of stage i feeds stage i+1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (S1[i]),
      .b    (S2[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  // Result registers only load on valid, so idle-cycle input garbage never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultado <= '0;
      C_out     <= 1'b0;
      out_valid <= 1'b0;
`ifdef SOMADOR_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        resultado <= {c[WIDTH], sum};
        C_out     <= c[WIDTH];
`ifdef SOMADOR_OVF_EN
        ovf       <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_somador_8bits.sv
// Scoreboard bench for somador_8bits: driver pushes expected sums, monitor pops and compares.
module tb_somador_8bits;
  import somador_pkg::*;

  logic     clk;
  logic     rst_n;
  operand_t s1, s2;
  logic     c_in;
  logic     in_valid;
  result_t  resultado;
  logic     c_out;
  logic     out_valid;
`ifdef SOMADOR_OVF_EN
  logic     ovf;
`endif

  typedef struct {
    int unsigned res;
    bit          cout;
    bit          ovf;
  } exp_t;

  exp_t        q[$];
  int unsigned last_res;
  bit          last_cout;
  bit          last_ovf;
  int          n_cmp;
  int          n_err;

  somador_8bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .S1        (s1),
    .S2        (s2),
    .C_in      (c_in),
    .in_valid  (in_valid),
    .resultado (resultado),
    .C_out     (c_out),
    .out_valid (out_valid)
`ifdef SOMADOR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic, signed view for overflow.
  function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned ci);
    exp_t e;
    int   sa, sb, ss;
    e.res  = a + b + ci;
    e.cout = (e.res >= 128);
    sa     = (a >= 64) ? int'(a) - 128 : int'(a);
    sb     = (b >= 64) ? int'(b) - 128 : int'(b);
    ss     = sa + sb + int'(ci);
    e.ovf  = (ss > 63) || (ss < -64);
    return e;
  endfunction

  task automatic drive(input int unsigned a, input int unsigned b, input int unsigned ci, input bit v);
    @(negedge clk);
    s1       = 7'(a);
    s2       = 7'(b);
    c_in     = 1'(ci);
    in_valid = v;
    if (v && rst_n) q.push_back(model(a, b, ci));
  endtask

  task automatic idle();
    drive($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 1), 1'b0);
  endtask

  // Monitor: one sample per cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("out_valid", 32'(out_valid), 1);
      chk("resultado", 32'(resultado), e.res);
      chk("C_out", 32'(c_out), 32'(e.cout));
`ifdef SOMADOR_OVF_EN
      chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
      last_res  = e.res;
      last_cout = e.cout;
      last_ovf  = e.ovf;
    end else begin
      chk("idle_out_valid", 32'(out_valid), 0);
      chk("hold_resultado", 32'(resultado), last_res);
      chk("hold_C_out", 32'(c_out), 32'(last_cout));
`ifdef SOMADOR_OVF_EN
      chk("hold_ovf", 32'(ovf), 32'(last_ovf));
`endif
    end
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    last_res  = 0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    rst_n     = 1'b0;
    s1        = '0;
    s2        = '0;
    c_in      = 1'b0;
    in_valid  = 1'b0;

    // Inputs toggling under reset must not load anything.
    for (int i = 0; i < 4; i++) drive($urandom_range(0, 127), $urandom_range(0, 127), 1, 1'b1);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    drive(5, 3, 0, 1'b1);
    drive(127, 127, 1, 1'b1);
    drive(64, 64, 0, 1'b1);
    drive(100, 27, 0, 1'b1);
    drive(1, 2, 0, 1'b1);
    drive(10, 20, 1, 1'b1);
    idle();
    idle();

    // Asynchronous reset between edges clears outputs before the next edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_resultado", 32'(resultado), 0);
    chk("async_rst_C_out", 32'(c_out), 0);
    chk("async_rst_out_valid", 32'(out_valid), 0);
    q.delete();
    last_res  = 0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      drive($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 1), 1'b1);
      if ($urandom_range(0, 3) == 0) idle();
    end

`ifdef SOMADOR_OVF_EN
    drive(63, 1, 0, 1'b1);
    drive(127, 1, 0, 1'b1);
    drive(64, 64, 0, 1'b1);
`endif
    idle();
    idle();
    idle();
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
